imem_loader: RTL
================

# imem_loader

Program loader that writes the instruction memory the fetch path reads. Accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, and issues one write per word at consecutive word addresses from the text-segment base. Holds the processor (`cpu_hold`) from reset until the load completes, so the PC never fetches a half-written program.

## Interface
- `BASE_ADDR`, 32'h00400000: byte address of the first word written.
- `DEPTH_WORDS`, 1024: number of writable words; the write index range is 0..DEPTH_WORDS-1.
- `clk` input 1: the single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begins a load; sampled only in IDLE or DONE.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_byte` input 8: stream byte.
- `in_last` input 1: qualifies the final byte of the program; meaningful only with `in_valid`.
- `in_ready` output 1: loader accepts a byte this cycle.
- `wr_en` output 1: one-cycle instruction-memory write strobe.
- `wr_addr` output 32: byte address of the write, word-aligned.
- `wr_data` output 32: word to write.
- `busy` output 1: load in progress.
- `done` output 1: load finished; held until `start` or `reset`.
- `error` output 1: overflow occurred; held until `start` or `reset`.
- `cpu_hold` output 1: processor stall/reset request.
- `word_count` output 11: words written in the current or last load.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE. Encodings live in the shared header.
- IDLE: `cpu_hold`=1. `start` moves to COLLECT and clears the byte counter, word index, `word_count`, `error`, and the assembly register.
- COLLECT: `in_ready`=1. A byte is accepted on `in_valid && in_ready`. The accepted byte is shifted into `asm_reg` with first byte → [31:24], so the stream order matches the hex word view. The byte counter (2 bits) increments.
- Leave COLLECT for WRITE when:
  - the 4th byte is accepted, or
  - `in_last` is accepted with 1–3 bytes. Unfilled low bytes are zero-padded; "01 02 + last" writes 32'h01020000.
- WRITE (1 cycle): `wr_en`=1, `wr_addr`=BASE_ADDR+4*index, `wr_data`=`asm_reg`, `in_ready`=0. Then index and `word_count` increment. Go to DONE if the word was last-terminated, else to COLLECT.
- Overflow: a byte accepted in COLLECT while index==DEPTH_WORDS is dropped (no write). Set `error`=1 and go to DONE.
- DONE: `done`=1, `cpu_hold`=0, `busy`=0, `in_ready`=0. `start` restarts the load (→ COLLECT, clears as in IDLE). Memory contents are never cleared by the loader.
- `busy`=1 in COLLECT and WRITE only.
- `start` while busy is ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `cpu_hold`=1, `word_count`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`in_byte` to any output.
- The write strobe occurs in the cycle after the word's final byte is accepted.
- Peak throughput: 4 bytes per 5 cycles. `in_ready` drops for exactly the WRITE cycle.
- `start` → `in_ready`=1: 1 cycle.
- Final write → `done`=1, `cpu_hold`=0: the next cycle.
- `reset` mid-load: the next cycle shows reset values. A write in flight on that edge is not issued. Partially assembled bytes are discarded.
- `in_valid` with `in_ready`=0: the byte is not consumed; the source holds it.
- Address wrap: not possible; the index saturates at DEPTH_WORDS and the overflow rule applies.

## Structure
- Shared constants go in `mips.h`: `IMEM_BASE` (32'h00400000) and the loader state encodings (`LD_IDLE`, `LD_COLLECT`, `LD_WRITE`, `LD_DONE`).
- One natural sub-module: `word_assembler`, the 32-bit shift/pack register with byte counter, zero-pad and clear controls. The FSM, index counter and handshake stay in `imem_loader`.
- Its write port drives a write-enabled instruction memory. `cpu_hold` gates the PC update.

## Test plan
- Reset, then idle 5 cycles: `cpu_hold`=1, `in_ready`=0, `wr_en`=0, `done`=0.
- `start`; stream 8 bytes 3C,01,10,01,08,10,00,00, last on the 8th:
  - writes 3C011001 @00400000, then 08100000 @00400004;
  - `word_count`=2; `done`=1 and `cpu_hold`=0 one cycle after the second write.
- 5 bytes AA,BB,CC,DD,EE with last on EE → writes AABBCCDD @00400000 and EE000000 @00400004.
- `in_valid` toggled every other cycle during a 4-byte word → same single write. No byte is lost or duplicated; `in_ready`=0 during WRITE.
- DEPTH_WORDS=2, 9 bytes → two writes, then the 9th byte is dropped: `error`=1, `done`=1, no third `wr_en`.
- `reset` asserted after 6 bytes → reset values next cycle, no write for bytes 5–6. A subsequent `start` restarts at 00400000.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared constants for the program loader: the text-segment base address,
//   the loader FSM state encodings and the byte-placement helper that packs
//   stream bytes big-endian into a 32-bit instruction word.
package imem_loader_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h0040_0000;
  localparam int          WC_W      = 11;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } ld_state_e;

  // Byte position 0 lands in [31:24], so the stream order matches the hex
  // word view. Lanes not yet written stay at their cleared value (zero),
  // which is what provides the zero-padding of a short final word.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  pos,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (pos)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler
//   32-bit pack register with a 2-bit byte counter. Bytes fill the word from
//   the most significant lane down; clearing zeroes both the word and the
//   counter so a short final word comes out zero-padded.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clear         zero the word and the byte counter
//   load          place byte_in at the current lane, advance the counter
//   byte_in       stream byte
//   word          assembled (zero-padded) word
//   byte_cnt      number of bytes held (0..3; wraps to 0 after the 4th)
//   last_lane     next loaded byte completes the word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        last_lane
);

  logic [31:0] asm_reg;
  logic [1:0]  cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      asm_reg <= '0;
      cnt     <= '0;
    end else if (load) begin
      asm_reg <= place_byte(asm_reg, cnt, byte_in);
      cnt     <= cnt + 2'd1;
    end
  end

  assign word      = asm_reg;
  assign byte_cnt  = cnt;
  assign last_lane = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program byte stream into instruction memory. Bytes arrive over
//   valid/ready, are packed big-endian into words and written one word per
//   WRITE cycle at consecutive addresses from BASE_ADDR. cpu_hold stays high
//   until the load finishes so the PC never fetches a half-written program.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       begin a load (honoured in IDLE or DONE only)
//   in_valid/in_byte/in_last    byte stream; in_last marks the final byte
//   in_ready                    loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data       one-cycle instruction-memory write port
//   busy, done, error           load status (done/error held until start)
//   cpu_hold                    processor stall request
//   word_count                  words written in the current or last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [31:0]     wr_addr,
  output logic [31:0]     wr_data,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_hold,
  output logic [WC_W-1:0] word_count
);

  localparam logic [WC_W-1:0] DEPTH_L = WC_W'(DEPTH_WORDS);

  ld_state_e       state, next_state;
  logic [WC_W-1:0] idx;
  logic            error_q;
  logic            last_q;
  logic [31:0]     word;
  logic [1:0]      byte_cnt;
  logic            last_lane;

  logic accept, full, starting;

  assign accept   = in_valid && (state == LD_COLLECT);
  // The index saturates at DEPTH_WORDS: no further writes are possible, so
  // the address can never wrap.
  assign full     = (idx == DEPTH_L);
  assign starting = start && ((state == LD_IDLE) || (state == LD_DONE));

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (starting || (state == LD_WRITE)),
    .load      (accept && !full),
    .byte_in   (in_byte),
    .word      (word),
    .byte_cnt  (byte_cnt),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LD_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default first so every path assigns it and
  // no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE:    if (start) next_state = LD_COLLECT;
      LD_COLLECT: begin
        if (accept) begin
          if (full)                       next_state = LD_DONE;
          else if (last_lane || in_last)  next_state = LD_WRITE;
        end
      end
      LD_WRITE:   next_state = last_q ? LD_DONE : LD_COLLECT;
      LD_DONE:    if (start) next_state = LD_COLLECT;
      default:    next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || starting) begin
      idx     <= '0;
      error_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (full) error_q <= 1'b1;
        else      last_q  <= in_last;
      end
      if (state == LD_WRITE) idx <= idx + 1'b1;
    end
  end

  // Outputs decode state and registers only; nothing passes combinationally
  // from the stream inputs. Address/data read zero outside WRITE.
  assign in_ready   = (state == LD_COLLECT);
  assign wr_en      = (state == LD_WRITE);
  assign wr_addr    = wr_en ? (BASE_ADDR + {19'd0, idx, 2'b00}) : 32'd0;
  assign wr_data    = wr_en ? word : 32'd0;
  assign busy       = (state == LD_COLLECT) || (state == LD_WRITE);
  assign done       = (state == LD_DONE);
  assign cpu_hold   = (state != LD_DONE);
  assign error      = error_q;
  assign word_count = idx;

endmodule
